// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one SRAM-like bus between the fetch port (I) and the
// data port (D). One transaction in flight; D wins ties; responses are routed
// back to the owning port; a new grant may overlap the previous response.
module cbus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_strobe,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_strobe,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state, state_next;
    logic                owner, owner_next;
    logic                wr_next;
    logic [WORD_W-1:0]   addr_next;
    logic [SIZE_W-1:0]   size_next;
    logic [STRB_W-1:0]   strobe_next;
    logic [WORD_W-1:0]   wdata_next;
    logic                can_grant;

    // Read data is shared; the data_ok pulses select who consumes it.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // State, owner and bus payload registers; the bus is driven straight from these.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            m_req    <= 1'b0;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            m_size   <= '0;
            m_strobe <= '0;
            m_wdata  <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            m_req    <= (state_next == ADDR);
            m_wr     <= wr_next;
            m_addr   <= addr_next;
            m_size   <= size_next;
            m_strobe <= strobe_next;
            m_wdata  <= wdata_next;
        end
    end

    // Next state, grant arbitration (D over I) and handshake pulses.
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        wr_next     = m_wr;
        addr_next   = m_addr;
        size_next   = m_size;
        strobe_next = m_strobe;
        wdata_next  = m_wdata;
        can_grant   = 1'b0;
        i_addr_ok   = 1'b0;
        d_addr_ok   = 1'b0;
        i_data_ok   = 1'b0;
        d_data_ok   = 1'b0;

        case (state)
            IDLE: can_grant = 1'b1;
            ADDR: if (m_addr_ok) state_next = DATA;
            DATA: begin
                if (m_data_ok) begin
                    can_grant  = 1'b1;
                    state_next = IDLE;
                    if (owner) d_data_ok = 1'b1;
                    else       i_data_ok = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Reuse the response cycle for the next grant so there is no bubble.
        if (can_grant) begin
            if (d_req) begin
                d_addr_ok   = 1'b1;
                state_next  = ADDR;
                owner_next  = 1'b1;
                wr_next     = d_wr;
                addr_next   = d_addr;
                size_next   = d_size;
                strobe_next = d_wr ? d_strobe : STRB_W'(0);
                wdata_next  = d_wdata;
            end else if (i_req) begin
                i_addr_ok   = 1'b1;
                state_next  = ADDR;
                owner_next  = 1'b0;
                wr_next     = 1'b0;
                addr_next   = i_addr;
                size_next   = i_size;
                strobe_next = '0;
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios followed by random
// traffic, all compared each cycle against a transaction-level model.
module tb_cbus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic [1:0]  i_size;
    logic        d_req, d_wr, d_addr_ok, d_data_ok;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic [3:0]  d_strobe;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_size;
    logic [3:0]  m_strobe;

    int errors = 0;
    int checks = 0;

    // Model: at most one transaction, which is either awaiting bus acceptance
    // or awaiting its response; the bus shows the payload of the last grant.
    bit          txn_live, txn_accepted, txn_from_d;
    bit          pay_wr;
    logic [31:0] pay_addr, pay_wdata;
    logic [1:0]  pay_size;
    logic [3:0]  pay_strobe;
    bit          exp_i_grant, exp_d_grant, exp_done;

    cbus_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_size(d_size),
        .d_strobe(d_strobe), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        txn_live = 0; txn_accepted = 0; txn_from_d = 0;
        pay_wr = 0; pay_addr = '0; pay_size = '0; pay_strobe = '0; pay_wdata = '0;
    endtask

    task automatic drive_quiet();
        i_req = 0; i_addr = '0; i_size = '0;
        d_req = 0; d_wr = 0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    // One clock cycle: inputs already driven just after the rising edge.
    task automatic step();
        if (reset) model_clear();
        @(negedge clk);
        exp_done    = txn_live && txn_accepted && m_data_ok;
        exp_d_grant = (!txn_live || exp_done) && d_req;
        exp_i_grant = (!txn_live || exp_done) && i_req && !d_req;
        check("i_addr_ok", 32'(i_addr_ok), 32'(exp_i_grant));
        check("d_addr_ok", 32'(d_addr_ok), 32'(exp_d_grant));
        check("i_data_ok", 32'(i_data_ok), 32'(exp_done && !txn_from_d));
        check("d_data_ok", 32'(d_data_ok), 32'(exp_done && txn_from_d));
        check("m_req", 32'(m_req), 32'(txn_live && !txn_accepted));
        check("m_wr", 32'(m_wr), 32'(pay_wr));
        check("m_addr", m_addr, pay_addr);
        check("m_size", 32'(m_size), 32'(pay_size));
        check("m_strobe", 32'(m_strobe), 32'(pay_strobe));
        check("m_wdata", m_wdata, pay_wdata);
        if (exp_done && txn_from_d)  check("d_rdata", d_rdata, m_rdata);
        if (exp_done && !txn_from_d) check("i_rdata", i_rdata, m_rdata);
        @(posedge clk);
        if (!reset) begin
            if (exp_done) txn_live = 0;
            else if (txn_live && !txn_accepted && m_addr_ok) txn_accepted = 1;
            if (exp_d_grant) begin
                txn_live = 1; txn_accepted = 0; txn_from_d = 1;
                pay_wr = d_wr; pay_addr = d_addr; pay_size = d_size;
                pay_strobe = d_wr ? d_strobe : 4'h0; pay_wdata = d_wdata;
            end else if (exp_i_grant) begin
                txn_live = 1; txn_accepted = 0; txn_from_d = 0;
                pay_wr = 0; pay_addr = i_addr; pay_size = i_size; pay_strobe = '0;
            end
        end
        #1;
    endtask

    bit          i_pend, d_pend;

    initial begin
        model_clear();
        drive_quiet();
        reset = 1;
        #1;
        step();
        reset = 0;
        step();

        // Single fetch
        i_req = 1; i_addr = 32'hBFC0_0000; i_size = 2'd2; step();
        i_req = 0; m_addr_ok = 1; step();
        m_addr_ok = 0; step();
        m_data_ok = 1; m_rdata = 32'h3C08_BFAF; step();
        m_data_ok = 0; step();

        // Store with bus acceptance delayed three cycles
        d_req = 1; d_wr = 1; d_addr = 32'h8000_1004; d_size = 2'd2;
        d_strobe = 4'hC; d_wdata = 32'h1234_5678; step();
        d_req = 0; step(); step(); step();
        m_addr_ok = 1; step();
        m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hDEAD_BEEF; step();
        m_data_ok = 0; step();

        // Contention: D load and fetch together
        i_req = 1; i_addr = 32'hBFC0_0010; i_size = 2'd2;
        d_req = 1; d_wr = 0; d_addr = 32'h8000_2000; d_strobe = 4'hF; step();
        d_req = 0; m_addr_ok = 1; step();
        m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0000_00AA; step();
        i_req = 0; m_data_ok = 0; m_addr_ok = 1; step();
        m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0000_00BB; step();
        m_data_ok = 0; step();

        // Back-to-back fetches with i_req held
        i_req = 1; i_addr = 32'hBFC0_0100; step();
        for (int k = 0; k < 3; k++) begin
            m_addr_ok = 1; m_data_ok = 0; step();
            i_addr = i_addr + 32'd4;
            m_addr_ok = 0; m_data_ok = 1; m_rdata = $urandom; step();
        end
        i_req = 0; m_data_ok = 0; m_addr_ok = 1; step();
        m_addr_ok = 0; m_data_ok = 1; step();
        m_data_ok = 0; step();

        // Spurious responses in IDLE and ADDR
        m_data_ok = 1; step(); step();
        m_data_ok = 0; i_req = 1; i_addr = 32'hBFC0_0200; step();
        i_req = 0; m_data_ok = 1; step();
        m_data_ok = 0; m_addr_ok = 1; step();
        m_addr_ok = 0; m_data_ok = 1; step();
        m_data_ok = 0; step();

        // Reset while a response is outstanding
        i_req = 1; i_addr = 32'hBFC0_0300; step();
        i_req = 0; m_addr_ok = 1; step();
        m_addr_ok = 0; reset = 1; step();
        reset = 0; m_data_ok = 1; step();
        m_data_ok = 0; i_req = 1; i_addr = 32'hBFC0_0400; step();
        i_req = 0; m_addr_ok = 1; step();
        m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1111_2222; step();
        drive_quiet(); step();

        // Random traffic; requesters hold their payload until accepted
        i_pend = 0; d_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                drive_quiet(); i_pend = 0; d_pend = 0;
                reset = 1; step();
                reset = 0;
                continue;
            end
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_addr = $urandom; i_size = 2'($urandom_range(0, 2));
            end
            if (!d_pend && $urandom_range(0, 3) == 0) begin
                d_pend = 1; d_wr = 1'($urandom); d_addr = $urandom;
                d_size = 2'($urandom_range(0, 2)); d_strobe = 4'($urandom);
                d_wdata = $urandom;
            end
            i_req = i_pend; d_req = d_pend;
            m_addr_ok = 1'($urandom); m_data_ok = 1'($urandom); m_rdata = $urandom;
            step();
            if (exp_i_grant) i_pend = 0;
            if (exp_d_grant) d_pend = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
